// File: rtl/botao_pkg.sv
// Shared types and helpers for the multi-channel button debouncer.
// Holds the per-channel FSM encoding and the counter-width function.
package botao_pkg;

  typedef enum logic [1:0] {SOLTO, PRESSIONADO, REPETINDO} estado_botao_t;

  // Bits needed to hold values 0..x; never less than one bit.
  function automatic int largura(input int x);
    return (x < 1) ? 1 : $clog2(x + 1);
  endfunction

endpackage

// File: rtl/botao_debounce_multicanal_if.sv
// Button bundle: raw inputs towards the debouncer, clean levels and event pulses back.
// The design side uses the slave modport; the board/stimulus side uses master.
interface botao_debounce_multicanal_if #(
  parameter int N_BOTOES = 4
);
  logic [N_BOTOES-1:0] botao;
  logic [N_BOTOES-1:0] estado;
  logic [N_BOTOES-1:0] pulso;
  logic [N_BOTOES-1:0] solto;
  logic [N_BOTOES-1:0] segurando;

  modport master (
    output botao,
    input  estado,
    input  pulso,
    input  solto,
    input  segurando
  );

  modport slave (
    input  botao,
    output estado,
    output pulso,
    output solto,
    output segurando
  );
endinterface

// File: rtl/botao_canal.sv
// One button channel: 2-flop synchroniser, stability-counter debounce, press/repeat/release FSM.
// Input is already active-high; every output is registered.
module botao_canal
  import botao_pkg::*;
#(
  parameter int DEBOUNCE_CICLOS = 500000,
  parameter int REPETE_ATRASO   = 25000000,
  parameter int REPETE_PERIODO  = 6250000
) (
  input  logic clk,
  input  logic reset,
  input  logic botao_i,
  output logic estado_o,
  output logic pulso_o,
  output logic solto_o,
  output logic segurando_o
);

  localparam int DW      = largura(DEBOUNCE_CICLOS);
  localparam int REP_MAX = (REPETE_ATRASO > REPETE_PERIODO) ? REPETE_ATRASO : REPETE_PERIODO;
  localparam int RW      = largura(REP_MAX);

  localparam logic [DW-1:0] DEB_FIM     = DW'(DEBOUNCE_CICLOS - 1);
  localparam logic [RW-1:0] ATRASO_FIM  = RW'(REPETE_ATRASO - 1);
  localparam logic [RW-1:0] PERIODO_FIM = RW'(REPETE_PERIODO - 1);

  logic          sync1_q, sync1_d;
  logic          s_q, s_d;
  logic          estado_q, estado_d;
  logic [DW-1:0] cnt_q, cnt_d;
  logic [RW-1:0] rep_q, rep_d, rep_inc;
  estado_botao_t fsm_q, fsm_d;
  logic          pulso_q, pulso_d;
  logic          solto_q, solto_d;
  logic          segurando_q, segurando_d;
  logic          subida, descida;

  always_comb begin
    sync1_d  = botao_i;
    s_d      = sync1_q;
    estado_d = estado_q;
    cnt_d    = cnt_q;
    subida   = 1'b0;
    descida  = 1'b0;
    if (s_q == estado_q) begin
      cnt_d = '0;
    end else if (cnt_q == DEB_FIM) begin
      estado_d = s_q;
      cnt_d    = '0;
      subida   = s_q;
      descida  = ~s_q;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Saturating increment: with auto-repeat disabled PRESSIONADO can last forever.
  assign rep_inc = (rep_q == '1) ? rep_q : rep_q + 1'b1;

  always_comb begin
    fsm_d       = fsm_q;
    rep_d       = rep_q;
    pulso_d     = 1'b0;
    solto_d     = 1'b0;
    segurando_d = segurando_q;
    // Release takes priority over a repeat maturing in the same cycle.
    if (descida) begin
      fsm_d       = SOLTO;
      rep_d       = '0;
      solto_d     = 1'b1;
      segurando_d = 1'b0;
    end else begin
      case (fsm_q)
        SOLTO: begin
          if (subida) begin
            pulso_d = 1'b1;
            rep_d   = '0;
            fsm_d   = PRESSIONADO;
          end
        end
        PRESSIONADO: begin
          if ((REPETE_ATRASO != 0) && (rep_q == ATRASO_FIM)) begin
            pulso_d     = 1'b1;
            rep_d       = '0;
            fsm_d       = REPETINDO;
            segurando_d = 1'b1;
          end else begin
            rep_d = rep_inc;
          end
        end
        REPETINDO: begin
          if (rep_q == PERIODO_FIM) begin
            pulso_d = 1'b1;
            rep_d   = '0;
          end else begin
            rep_d = rep_inc;
          end
        end
        default: fsm_d = SOLTO;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q     <= 1'b0;
      s_q         <= 1'b0;
      estado_q    <= 1'b0;
      cnt_q       <= '0;
      rep_q       <= '0;
      fsm_q       <= SOLTO;
      pulso_q     <= 1'b0;
      solto_q     <= 1'b0;
      segurando_q <= 1'b0;
    end else begin
      sync1_q     <= sync1_d;
      s_q         <= s_d;
      estado_q    <= estado_d;
      cnt_q       <= cnt_d;
      rep_q       <= rep_d;
      fsm_q       <= fsm_d;
      pulso_q     <= pulso_d;
      solto_q     <= solto_d;
      segurando_q <= segurando_d;
    end
  end

  assign estado_o    = estado_q;
  assign pulso_o     = pulso_q;
  assign solto_o     = solto_q;
  assign segurando_o = segurando_q;

endmodule

// File: rtl/botao_debounce_multicanal.sv
// N independent debounced buttons with press/auto-repeat/release pulses.
// Optional polarity inversion is applied before each channel's synchroniser.
module botao_debounce_multicanal
  import botao_pkg::*;
#(
  parameter int N_BOTOES        = 4,
  parameter int DEBOUNCE_CICLOS = 500000,
  parameter int REPETE_ATRASO   = 25000000,
  parameter int REPETE_PERIODO  = 6250000,
  parameter bit ATIVO_BAIXO     = 1'b0
) (
  input logic                         clk,
  input logic                         reset,
  botao_debounce_multicanal_if.slave  bus
);

  logic [N_BOTOES-1:0] botao_ativo;

  assign botao_ativo = bus.botao ^ {N_BOTOES{ATIVO_BAIXO}};

  for (genvar i = 0; i < N_BOTOES; i++) begin : g_canal
    botao_canal #(
      .DEBOUNCE_CICLOS (DEBOUNCE_CICLOS),
      .REPETE_ATRASO   (REPETE_ATRASO),
      .REPETE_PERIODO  (REPETE_PERIODO)
    ) u_canal (
      .clk         (clk),
      .reset       (reset),
      .botao_i     (botao_ativo[i]),
      .estado_o    (bus.estado[i]),
      .pulso_o     (bus.pulso[i]),
      .solto_o     (bus.solto[i]),
      .segurando_o (bus.segurando[i])
    );
  end

endmodule

// File: tb/tb_botao_debounce_multicanal.sv
// Directed bench: an active-high DUT with auto-repeat and an active-low DUT without it.
module tb_botao_debounce_multicanal;

  logic clk;
  logic reset;
  int   n_pass;
  int   n_total;

  botao_debounce_multicanal_if #(.N_BOTOES(2)) bus_a ();
  botao_debounce_multicanal_if #(.N_BOTOES(2)) bus_b ();

  botao_debounce_multicanal #(
    .N_BOTOES(2), .DEBOUNCE_CICLOS(4), .REPETE_ATRASO(10), .REPETE_PERIODO(3), .ATIVO_BAIXO(1'b0)
  ) dut_a (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_a)
  );

  botao_debounce_multicanal #(
    .N_BOTOES(2), .DEBOUNCE_CICLOS(4), .REPETE_ATRASO(0), .REPETE_PERIODO(3), .ATIVO_BAIXO(1'b1)
  ) dut_b (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] botao;
    logic [1:0] estado;
    logic [1:0] pulso;
    logic [1:0] solto;
    logic [1:0] segurando;
  } vetor_t;

  vetor_t tab [50];

  task automatic chk(input string nome, input logic [31:0] atual, input logic [31:0] esperado);
    n_total++;
    if (atual === esperado) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nome, atual, esperado, $time);
  endtask

  task automatic borda();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int np, ns, nseg;
    n_pass  = 0;
    n_total = 0;

    // Row e-1 holds input driven before edge e and outputs expected after edge e.
    // Hold ch0 for edges 1..40: press at 6, first repeat at 16, then every 3;
    // the debounced fall at 46 coincides with a repeat and must suppress it.
    for (int e = 1; e <= 50; e++) begin
      tab[e-1].botao     = {1'b0, (e <= 40)};
      tab[e-1].estado    = {1'b0, (e >= 6 && e <= 45)};
      tab[e-1].pulso     = {1'b0, (e == 6) || (e >= 16 && e <= 43 && ((e - 16) % 3) == 0)};
      tab[e-1].solto     = {1'b0, (e == 46)};
      tab[e-1].segurando = {1'b0, (e >= 16 && e <= 45)};
    end

    reset       = 1'b1;
    bus_a.botao = 2'b00;
    bus_b.botao = 2'b11;
    repeat (3) borda();
    chk("rst_estado",    32'(bus_a.estado),    32'd0);
    chk("rst_pulso",     32'(bus_a.pulso),     32'd0);
    chk("rst_solto",     32'(bus_a.solto),     32'd0);
    chk("rst_segurando", 32'(bus_a.segurando), 32'd0);
    chk("rst_b_estado",  32'(bus_b.estado),    32'd0);
    reset = 1'b0;

    // Clean press, auto-repeat, release colliding with a repeat
    for (int i = 0; i < 50; i++) begin
      bus_a.botao = tab[i].botao;
      borda();
      chk($sformatf("tab%0d_estado", i + 1),    32'(bus_a.estado),    32'(tab[i].estado));
      chk($sformatf("tab%0d_pulso", i + 1),     32'(bus_a.pulso),     32'(tab[i].pulso));
      chk($sformatf("tab%0d_solto", i + 1),     32'(bus_a.solto),     32'(tab[i].solto));
      chk($sformatf("tab%0d_segurando", i + 1), 32'(bus_a.segurando), 32'(tab[i].segurando));
    end
    chk("release_pulso_vs_solto", 32'(bus_a.pulso & bus_a.solto), 32'd0);

    // Bounce: 2-cycle glitches never mature
    for (int i = 0; i < 8; i++) begin
      bus_a.botao = {1'b0, (i % 4) < 2};
      borda();
      chk($sformatf("bounce%0d_pulso", i), 32'(bus_a.pulso), 32'd0);
      chk($sformatf("bounce%0d_estado", i), 32'(bus_a.estado), 32'd0);
    end
    bus_a.botao = 2'b01;
    for (int k = 1; k <= 7; k++) begin
      borda();
      chk($sformatf("bounce_final_e%0d_pulso", k), 32'(bus_a.pulso), (k == 6) ? 32'd1 : 32'd0);
    end
    bus_a.botao = 2'b00;
    np = 0; ns = 0;
    for (int k = 1; k <= 8; k++) begin
      borda();
      np += int'(bus_a.pulso[0]);
      ns += int'(bus_a.solto[0]);
    end
    chk("bounce_release_pulsos", 32'(np), 32'd0);
    chk("bounce_release_soltos", 32'(ns), 32'd1);
    chk("bounce_release_estado", 32'(bus_a.estado), 32'd0);

    // Channel 1 alone
    bus_a.botao = 2'b10;
    for (int k = 1; k <= 6; k++) begin
      borda();
      chk($sformatf("ch1_e%0d_pulso", k), 32'(bus_a.pulso), (k == 6) ? 32'd2 : 32'd0);
    end
    chk("ch1_estado", 32'(bus_a.estado), 32'd2);
    bus_a.botao = 2'b00;
    repeat (8) borda();
    chk("ch1_released", 32'(bus_a.estado), 32'd0);

    // Async reset while repeating
    bus_a.botao = 2'b01;
    repeat (20) borda();
    chk("pre_rst_segurando", 32'(bus_a.segurando), 32'd1);
    chk("pre_rst_estado",    32'(bus_a.estado),    32'd1);
    #3;
    reset = 1'b1;
    #1;
    chk("async_rst_estado",    32'(bus_a.estado),    32'd0);
    chk("async_rst_segurando", 32'(bus_a.segurando), 32'd0);
    chk("async_rst_pulso",     32'(bus_a.pulso),     32'd0);
    borda();
    reset = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      borda();
      chk($sformatf("post_rst_e%0d_pulso", k), 32'(bus_a.pulso), (k == 6) ? 32'd1 : 32'd0);
    end
    bus_a.botao = 2'b00;
    repeat (8) borda();
    chk("post_rst_released", 32'(bus_a.estado), 32'd0);

    // Active-low, repeat disabled
    bus_b.botao = 2'b10;
    np = 0; nseg = 0;
    for (int k = 1; k <= 30; k++) begin
      borda();
      np   += int'(bus_b.pulso[0]);
      nseg += int'(bus_b.segurando[0]);
    end
    chk("b_press_pulsos",    32'(np),           32'd1);
    chk("b_press_segurando", 32'(nseg),         32'd0);
    chk("b_press_estado",    32'(bus_b.estado), 32'd1);
    bus_b.botao = 2'b11;
    np = 0; ns = 0;
    for (int k = 1; k <= 10; k++) begin
      borda();
      np += int'(bus_b.pulso[0]);
      ns += int'(bus_b.solto[0]);
    end
    chk("b_release_soltos", 32'(ns),           32'd1);
    chk("b_release_pulsos", 32'(np),           32'd0);
    chk("b_release_estado", 32'(bus_b.estado), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/botao_debounce_multicanal.md
Name: botao_debounce_multicanal

Overview:
- N-channel successor to the single-button debounce/jump timer.
- Synchronises each raw push-button, debounces it with a stability counter, and emits a clean level plus one-cycle event pulses.
- Press events auto-repeat while the button is held.
- Sits between the board buttons and game/control FSMs (jump, menu navigation). Replaces per-button ad-hoc timers.

Parameters:
- N_BOTOES, 4, number of independent button channels (1..16)
- DEBOUNCE_CICLOS, 500000, cycles the synchronised input must differ from the current stable level before the level flips (>=1)
- REPETE_ATRASO, 25000000, cycles from the press pulse to the first auto-repeat pulse; 0 disables auto-repeat
- REPETE_PERIODO, 6250000, cycles between subsequent auto-repeat pulses (>=1)
- ATIVO_BAIXO, 0, 1 = raw input is active-low; it is inverted before synchronisation

Ports:
- clk, input, 1, system clock
- reset, input, 1, asynchronous active-high reset
- botao, input, N_BOTOES, raw asynchronous button inputs
- estado, output, N_BOTOES, debounced stable level, 1 = pressed
- pulso, output, N_BOTOES, one-cycle pulse on debounced press and on each auto-repeat
- solto, output, N_BOTOES, one-cycle pulse on debounced release
- segurando, output, N_BOTOES, 1 while the channel is in auto-repeat mode

Behaviour:
- Channels are fully independent; the rules below apply per channel i.
- Reset (async, any time, including mid-count or mid-repeat):
  - sync FFs, estado, pulso, solto, segurando, all counters and FSM cleared to 0 / SOLTO.
  - No pulse is generated on reset entry or exit.
- Synchroniser: two flops on (botao xor ATIVO_BAIXO) produce s.
- Debounce counter (width $clog2(DEBOUNCE_CICLOS+1)):
  - If s == estado: counter <= 0.
  - Else if counter == DEBOUNCE_CICLOS-1: estado <= s, counter <= 0.
  - Else: counter++.
  - Any bounce shorter than DEBOUNCE_CICLOS restarts the count.
- Latency: input held from before edge 1 gives estado high after edge DEBOUNCE_CICLOS+2. Release has the same latency.
- FSM states: SOLTO, PRESSIONADO, REPETINDO.
  - SOLTO: on the debounced rise, pulso=1 for 1 cycle (same edge estado rises), rep counter <= 0, go to PRESSIONADO.
  - PRESSIONADO:
    - Rep counter increments each cycle.
    - When it equals REPETE_ATRASO-1 (and REPETE_ATRASO != 0): pulso=1, counter <= 0, go to REPETINDO, segurando <= 1.
    - If REPETE_ATRASO == 0: stay in PRESSIONADO with no repeats.
  - REPETINDO: counter increments; at REPETE_PERIODO-1, pulso=1 and counter <= 0.
  - Any state, on the debounced fall: solto=1 for 1 cycle, segurando <= 0, go to SOLTO. No pulso in that cycle, even if the repeat count matures simultaneously (release wins).
- Event spacing: the first repeat pulse comes REPETE_ATRASO cycles after the press pulse; later repeats are every REPETE_PERIODO cycles.
- pulso and solto are never high in the same cycle. All outputs are registered.
- Rep counter width: $clog2(max(REPETE_ATRASO, REPETE_PERIODO)+1). It saturates logically; it never wraps because it is compared for equality and cleared.

Decomposition:
- Package botao_pkg:
  - typedef enum logic [1:0] {SOLTO, PRESSIONADO, REPETINDO} estado_botao_t
  - function largura(int) wrapping $clog2(x+1)
- Sub-module botao_canal: one channel (sync, debounce, FSM), parameterised identically minus N_BOTOES.
- Top: generate-for of N_BOTOES instances, plus ATIVO_BAIXO inversion.

Test Plan:
Bench parameters: N_BOTOES=2, DEBOUNCE_CICLOS=4, REPETE_ATRASO=10, REPETE_PERIODO=3.
1. Clean press: botao[0]=1 before edge 1 -> estado[0] and pulso[0] high after edge 6; pulso[0] low after edge 7; channel 1 unaffected.
2. Bounce: botao[0] toggles 1,0,1 with 2-cycle glitches, then holds 1 -> no event during the glitches; single pulso 6 edges after the final stable 1.
3. Auto-repeat: hold botao[0] for 40 cycles -> pulso at edges 6, 16, 19, 22, 25, ...; segurando high from edge 16; release gives solto 6 edges after the release, with segurando and estado going to 0.
4. Simultaneous release and repeat: release timed so the debounced fall coincides with a repeat-count maturity -> solto=1, pulso=0 in that cycle.
5. Reset mid-operation: assert reset during REPETINDO -> all outputs 0 immediately (async). With botao still held after reset deasserts -> fresh pulso 6 edges later.
6. ATIVO_BAIXO=1, REPETE_ATRASO=0: drive botao low and hold 30 cycles -> exactly one pulso; segurando stays 0; driving high gives one solto.
